phy_rx_serial_to_parallel: RTL and testbench
============================================

PHY_RX_SERIAL_TO_PARALLEL -- requirements
Module: phy_rx_serial_to_parallel

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk_32f  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: serial_in  input  1  received line bit, sampled every clk_32f edge, MSB of each byte first.
REQ-005 Port: data_out  output  8  recovered byte, registered.
REQ-006 Port: valid_out  output  1  high for one cycle when data_out carries a non-COM byte in LOCKED.
REQ-007 Port: byte_strobe  output  1  one-cycle pulse on every byte boundary while LOCKED, for COM and non-COM bytes.
REQ-008 Port: active  output  1  high while the state is LOCKED.
REQ-009 Parameter: COM, default 8'hBC, comma symbol used for alignment.
REQ-010 Parameter: LOCK_COUNT, default 4, number of consecutive aligned COMs required to lock.

Function
REQ-011 An 8-bit shift register SHALL update every cycle as next_sr = {sr[6:0], serial_in}.
REQ-012 The FSM SHALL have exactly three states: SEARCH, ALIGN and LOCKED.
REQ-013 SEARCH: on any edge where next_sr == COM, the FSM SHALL clear bit_cnt to 0, set com_cnt to 1 and go to ALIGN; otherwise it stays in SEARCH.
REQ-014 In ALIGN and LOCKED, bit_cnt (3 bits) SHALL increment every cycle and wrap 7->0; a byte completes on the edge where bit_cnt == 7, with byte = next_sr.
REQ-015 ALIGN, completed byte == COM: com_cnt SHALL increment; when com_cnt reaches LOCK_COUNT the FSM goes to LOCKED.
REQ-016 ALIGN, completed byte != COM: the FSM SHALL return to SEARCH and clear com_cnt; that byte SHALL NOT be searched for an embedded COM.
REQ-017 LOCKED, each completed byte: data_out SHALL be loaded with the byte; byte_strobe = 1; valid_out = 1 if the byte != COM, else 0.
REQ-018 Outputs SHALL be registered: the 8th bit of a byte is sampled at edge N, and data_out, valid_out and byte_strobe become visible after edge N (one-edge latency).
REQ-019 valid_out and byte_strobe SHALL be 0 on every cycle that is not a byte-completion edge in LOCKED; data_out holds its last value between bytes.
REQ-020 active SHALL be set on the same edge as the LOCKED transition; the first data_out update happens on the next byte boundary.
REQ-021 LOCKED SHALL be held until reset; there is no loss-of-lock detection.
REQ-022 com_cnt SHALL saturate at LOCK_COUNT, with no wrap-around.

Reset
REQ-023 While reset is high at an edge, the block SHALL set state=SEARCH, sr=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0, byte_strobe=0 and active=0.
REQ-024 Reset SHALL take priority over every transition, including in mid-byte or LOCKED; serial_in sampled on a reset edge is discarded.

Structure
REQ-025 The COM value, LOCK_COUNT and the state encoding (SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2) SHALL be defined in the shared PHY constants include used by the other PHY stages.
REQ-026 The block SHALL be a single module with no sub-module; the shift register, counters and FSM are flat, and the expected size is ~150 RTL lines.

Verification
REQ-027 Reset, then 4x 0xBC followed by 0x55 and 0xA3 -> active rises after the 4th COM; data_out=0x55 with valid_out=1, then 0xA3 with valid_out=1, each with a one-cycle byte_strobe.
REQ-028 3x 0xBC then 0x00, then 4x 0xBC and 0x7E -> active stays 0 through the 0x00, then locks; data_out=0x7E with valid_out=1.
REQ-029 3 junk bits (101), then 4x 0xBC, then 0x12 -> lock is achieved despite the misalignment; data_out=0x12.
REQ-030 LOCKED, then 0xBC then 0x34 -> byte_strobe pulses for both; data_out=0xBC with valid_out=0, then data_out=0x34 with valid_out=1.
REQ-031 Reset asserted for 1 cycle mid-byte while LOCKED -> all outputs 0 after that edge, state=SEARCH; relock requires 4 fresh COMs.
REQ-032 serial_in held at 0 for 64 cycles after reset -> active=0, valid_out=0 and byte_strobe=0 throughout.

Source files
------------

// File: rtl/phy_rx_serial_to_parallel_pkg.sv
// Shared PHY receive constants: comma symbol, lock threshold and aligner state encoding.
package phy_rx_serial_to_parallel_pkg;

  localparam logic [7:0] PHY_COM        = 8'hBC;
  localparam int         PHY_LOCK_COUNT = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_serial_to_parallel.sv
// Serial-to-parallel receiver with comma-based byte alignment.
// Locks after LOCK_COUNT consecutive byte-aligned COMs and stays locked until reset.
module phy_rx_serial_to_parallel
  import phy_rx_serial_to_parallel_pkg::*;
#(
  parameter logic [7:0] COM        = PHY_COM,
  parameter int         LOCK_COUNT = PHY_LOCK_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int             CW       = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]  LOCK_CNT = CW'(LOCK_COUNT);

  rx_state_e      state, state_nx;
  logic [7:0]     sr, next_sr;
  logic [2:0]     bit_cnt, bit_cnt_nx;
  logic [CW-1:0]  com_cnt, com_cnt_nx, com_inc;
  logic [7:0]     data_nx;
  logic           valid_nx, strobe_nx;
  logic           byte_done;

  assign next_sr   = {sr[6:0], serial_in};
  assign byte_done = (bit_cnt == 3'd7);
  assign com_inc   = (com_cnt >= LOCK_CNT) ? com_cnt : com_cnt + CW'(1);

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt + 3'd1;
    com_cnt_nx = com_cnt;
    data_nx    = data_out;
    valid_nx   = 1'b0;
    strobe_nx  = 1'b0;
    unique case (state)
      SEARCH: begin
        // Bit-wise hunt: any window matching COM defines the byte boundary.
        bit_cnt_nx = bit_cnt;
        if (next_sr == COM) begin
          bit_cnt_nx = 3'd0;
          com_cnt_nx = CW'(1);
          state_nx   = (LOCK_COUNT <= 1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        if (byte_done) begin
          if (next_sr == COM) begin
            com_cnt_nx = com_inc;
            if (com_inc == LOCK_CNT) state_nx = LOCKED;
          end else begin
            com_cnt_nx = '0;
            state_nx   = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (byte_done) begin
          data_nx   = next_sr;
          strobe_nx = 1'b1;
          valid_nx  = (next_sr != COM);
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= SEARCH;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      com_cnt     <= '0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nx;
      sr          <= next_sr;
      bit_cnt     <= bit_cnt_nx;
      com_cnt     <= com_cnt_nx;
      data_out    <= data_nx;
      valid_out   <= valid_nx;
      byte_strobe <= strobe_nx;
      active      <= (state_nx == LOCKED);
    end
  end

endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// Directed bench: byte-vector table plus hand sequences for misalignment, mid-byte reset and idle line.
module tb_phy_rx_serial_to_parallel;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int errors = 0;
  int checks = 0;

  phy_rx_serial_to_parallel dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    bit         rst;
    logic [7:0] tx;
    bit         act;
    bit         stb;
    bit         vld;
    logic [7:0] dat;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_out(input string name, input bit a, input bit s, input bit v, input logic [7:0] d);
    chk({name, ".active"}, {7'd0, active}, {7'd0, a});
    chk({name, ".strobe"}, {7'd0, byte_strobe}, {7'd0, s});
    chk({name, ".valid"}, {7'd0, valid_out}, {7'd0, v});
    chk({name, ".data"}, data_out, d);
  endtask

  // Sends a byte MSB first; strobe/valid must stay low on the first seven edges.
  task automatic send_byte(input logic [7:0] b);
    logic mid_bad;
    mid_bad = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      if (byte_strobe || valid_out) mid_bad = 1'b1;
    end
    send_bit(b[0]);
    chk("midbyte_quiet", {7'd0, mid_bad}, 8'd0);
  endtask

  initial begin
    logic [7:0] junk;
    logic [7:0] b55;
    logic       bad;

    tv[0]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[3]  = '{1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[4]  = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55};
    tv[5]  = '{1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3};
    tv[6]  = '{1'b0, 8'hBC, 1'b1, 1'b1, 1'b0, 8'hBC};
    tv[7]  = '{1'b0, 8'h34, 1'b1, 1'b1, 1'b1, 8'h34};
    tv[8]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[9]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[10] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[12] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[13] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[14] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[15] = '{1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[16] = '{1'b0, 8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E};

    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (2) @(posedge clk_32f);
    #1;
    chk_out("reset_state", 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;

    // Lock, data, in-lock COM, then reset and a failed partial alignment before relock.
    for (int i = 0; i < 17; i++) begin
      if (tv[i].rst) begin
        do_reset();
        chk_out($sformatf("tv%0d_rst", i), 1'b0, 1'b0, 1'b0, 8'h00);
      end
      send_byte(tv[i].tx);
      chk_out($sformatf("tv%0d", i), tv[i].act, tv[i].stb, tv[i].vld, tv[i].dat);
    end
    send_bit(1'b0);
    chk_out("after_7e_strobe_drop", 1'b1, 1'b0, 1'b0, 8'h7E);

    // Three junk bits ahead of the commas.
    do_reset();
    junk = 8'b1010_0000;
    for (int i = 7; i >= 5; i--) send_bit(junk[i]);
    chk_out("junk", 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    chk_out("junk_lock", 1'b1, 1'b0, 1'b0, 8'h00);
    send_byte(8'h12);
    chk_out("junk_data", 1'b1, 1'b1, 1'b1, 8'h12);

    // Reset four bits into a byte while locked, then four fresh commas to relock.
    b55 = 8'h55;
    for (int i = 7; i >= 4; i--) send_bit(b55[i]);
    do_reset();
    chk_out("midbyte_reset", 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk_out("relock_3com", 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'hBC);
    chk_out("relock_4com", 1'b1, 1'b0, 1'b0, 8'h00);
    send_byte(8'h9A);
    chk_out("relock_data", 1'b1, 1'b1, 1'b1, 8'h9A);

    // Idle-low line must never lock or strobe.
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send_bit(1'b0);
      if (active || valid_out || byte_strobe) bad = 1'b1;
    end
    chk("idle_zero_quiet", {7'd0, bad}, 8'd0);
    chk("idle_zero_data", data_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
